front_line_buffer: RTL and testbench

- Double-buffered (ping-pong) sprite line buffer downstream of the front sprite layer.
- Consumes the serialised front pixel stream (FD) and the per-sprite line position (FL_Y).
- While one bank is filled with the next line's sprites, the other bank is read out to the colour mixer at pixel rate and cleared behind the read.
- Banks swap on every line toggle.

---
 rtl/front_line_buffer.sv | 190 +++++++++++++++++++
 tb/tb_front_line_buffer.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/front_line_buffer.sv
// Ping-pong sprite line buffer that sits after the front sprite layer.
// One bank collects the next line's sprite strips while the other bank is read
// out to the colour mixer and cleared behind the read. The banks swap on every
// line toggle. After reset both banks are swept to CLR_VAL before use.
//
// Ports:
//   clk          system clock, all logic on posedge
//   RESETn       synchronous active-low reset
//   pix_cen_i    pixel-rate clock enable (one clk wide)
//   line_tgl_i   line start pulse, swaps write/read banks
//   spr_start_i  starts a sprite strip at fl_y_i (coincident with pix_cen_i)
//   fl_y_i       strip start position
//   fd_i         front pixel {0, colour bank[3:0], pixel[2:0]}
//   rd_x_i       readout position from the horizontal counter
//   pix_out_o    buffered pixel for the mixer (1 pixel-enable latency)
//   pix_valid_o  pix_out_o[2:0] is not the transparent code
//   busy_o       post-reset clear sweep in progress
module front_line_buffer #(
   parameter int unsigned ADDR_W  = 9,
   parameter int unsigned SPR_W   = 16,
   parameter logic [2:0]  TRANSP  = 3'b111,
   parameter logic [7:0]  CLR_VAL = 8'h07
) (
   input  logic       clk,
   input  logic       RESETn,
   input  logic       pix_cen_i,
   input  logic       line_tgl_i,
   input  logic       spr_start_i,
   input  logic [8:0] fl_y_i,
   input  logic [7:0] fd_i,
   input  logic [8:0] rd_x_i,
   output logic [7:0] pix_out_o,
   output logic       pix_valid_o,
   output logic       busy_o
);

   localparam int unsigned Depth = 1 << ADDR_W;
   localparam int unsigned CntW  = $clog2(SPR_W) + 1;

   typedef enum logic [1:0] {StClear, StIdle, StWrite} state_e;

   state_e              state_q, state_d;
   logic                bank_sel_q, bank_sel_d;
   logic [ADDR_W-1:0]   wptr_q, wptr_d;
   logic [ADDR_W-1:0]   clr_addr_q, clr_addr_d;
   logic [CntW-1:0]     wcnt_q, wcnt_d;
   logic [7:0]          pix_out_q, pix_out_d;
   logic                pix_valid_q, pix_valid_d;

   logic [7:0]          mem0 [Depth];
   logic [7:0]          mem1 [Depth];

   logic                tgl;
   logic                start;
   logic                cur_bank;
   logic                strip_active;
   logic                strip_step;
   logic                strip_we;
   logic [ADDR_W-1:0]   strip_addr;
   logic [CntW-1:0]     strip_cnt;
   logic [CntW-1:0]     strip_cnt_nxt;
   logic [ADDR_W-1:0]   rd_addr;
   logic                rd_step;
   logic [7:0]          rd_data;

   logic                b0_we, b1_we;
   logic [ADDR_W-1:0]   b0_addr, b1_addr;
   logic [7:0]          b0_data, b1_data;

   // A toggle in the same clk as a write or read already uses the swapped banks,
   // so a strip started with the toggle lands wholly in the new write bank and
   // the two ports still never share a bank.
   always_comb begin
      tgl           = line_tgl_i && (state_q != StClear);
      start         = spr_start_i && (state_q != StClear);
      cur_bank      = bank_sel_q ^ tgl;
      strip_active  = start || (state_q == StWrite);
      strip_addr    = start ? fl_y_i[ADDR_W-1:0] : wptr_q;
      strip_cnt     = start ? '0 : wcnt_q;
      strip_cnt_nxt = strip_cnt + CntW'(1);
      strip_step    = strip_active && pix_cen_i;
      strip_we      = strip_step && (fd_i[2:0] != TRANSP);
      rd_addr       = rd_x_i[ADDR_W-1:0];
      rd_step       = pix_cen_i && (state_q != StClear);
      rd_data       = cur_bank ? mem0[rd_addr] : mem1[rd_addr];
   end

   // FSM: state register
   always_ff @(posedge clk) begin
      if (!RESETn) state_q <= StClear;
      else         state_q <= state_d;
   end

   // FSM: next state
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StClear: if (&clr_addr_q) state_d = StIdle;
         StIdle, StWrite: begin
            if (start) state_d = StWrite;
            if (strip_step && (strip_cnt_nxt == CntW'(SPR_W))) state_d = StIdle;
         end
         default: state_d = StClear;
      endcase
   end

   // FSM: outputs and bank port steering
   always_comb begin
      busy_o  = (state_q == StClear);
      b0_we   = 1'b0;
      b0_addr = '0;
      b0_data = CLR_VAL;
      b1_we   = 1'b0;
      b1_addr = '0;
      b1_data = CLR_VAL;
      if (state_q == StClear) begin
         b0_we   = 1'b1;
         b0_addr = clr_addr_q;
         b1_we   = 1'b1;
         b1_addr = clr_addr_q;
      end else if (cur_bank == 1'b0) begin
         b0_we   = strip_we;
         b0_addr = strip_addr;
         b0_data = fd_i;
         b1_we   = rd_step;
         b1_addr = rd_addr;
      end else begin
         b1_we   = strip_we;
         b1_addr = strip_addr;
         b1_data = fd_i;
         b0_we   = rd_step;
         b0_addr = rd_addr;
      end
   end

   // Datapath next state
   always_comb begin
      bank_sel_d  = bank_sel_q;
      wptr_d      = wptr_q;
      wcnt_d      = wcnt_q;
      clr_addr_d  = clr_addr_q;
      pix_out_d   = pix_out_q;
      pix_valid_d = pix_valid_q;
      if (state_q == StClear) clr_addr_d = clr_addr_q + ADDR_W'(1);
      if (tgl) bank_sel_d = ~bank_sel_q;
      if (start) begin
         wptr_d = strip_addr;
         wcnt_d = '0;
      end
      if (strip_step) begin
         wptr_d = strip_addr + ADDR_W'(1);
         wcnt_d = strip_cnt_nxt;
      end
      if (rd_step) begin
         pix_out_d   = rd_data;
         pix_valid_d = (rd_data[2:0] != TRANSP);
      end
   end

   always_ff @(posedge clk) begin
      if (!RESETn) begin
         bank_sel_q  <= 1'b0;
         wptr_q      <= '0;
         wcnt_q      <= '0;
         clr_addr_q  <= '0;
         pix_out_q   <= CLR_VAL;
         pix_valid_q <= 1'b0;
      end else begin
         bank_sel_q  <= bank_sel_d;
         wptr_q      <= wptr_d;
         wcnt_q      <= wcnt_d;
         clr_addr_q  <= clr_addr_d;
         pix_out_q   <= pix_out_d;
         pix_valid_q <= pix_valid_d;
      end
   end

   // Read data is taken combinationally before these writes land (read-before-write).
   always_ff @(posedge clk) begin
      if (RESETn && b0_we) mem0[b0_addr] <= b0_data;
   end

   always_ff @(posedge clk) begin
      if (RESETn && b1_we) mem1[b1_addr] <= b1_data;
   end

   assign pix_out_o   = pix_out_q;
   assign pix_valid_o = pix_valid_q;

endmodule

// File: tb/tb_front_line_buffer.sv
// Directed bench for front_line_buffer: expected readout values are queued
// when a read is driven and popped when the pixel appears one enable later.
`timescale 1ns/1ps
module tb_front_line_buffer;

   logic       clk;
   logic       RESETn;
   logic       pix_cen;
   logic       line_tgl;
   logic       spr_start;
   logic [8:0] fl_y;
   logic [7:0] fd;
   logic [8:0] rd_x;
   logic [7:0] pix_out;
   logic       pix_valid;
   logic       busy;

   int         vectors = 0;
   int         fails   = 0;
   logic [8:0] sb_q [$];
   logic [7:0] img [512];

   front_line_buffer dut (
      .clk         (clk),
      .RESETn      (RESETn),
      .pix_cen_i   (pix_cen),
      .line_tgl_i  (line_tgl),
      .spr_start_i (spr_start),
      .fl_y_i      (fl_y),
      .fd_i        (fd),
      .rd_x_i      (rd_x),
      .pix_out_o   (pix_out),
      .pix_valid_o (pix_valid),
      .busy_o      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      vectors++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
      end
   endtask

   // Waits out the clear sweep while throwing ignored traffic at the block.
   task automatic wait_clear(input string tag);
      int n;
      n = 0;
      do begin
         pix_cen   = n[0];
         rd_x      = 9'($urandom);
         fd        = 8'h11;
         fl_y      = 9'd20;
         spr_start = (n == 101);
         line_tgl  = (n == 201);
         step();
         n++;
         chk({tag, "_pix"}, {7'd0, pix_valid, pix_out}, 16'h0007);
      end while (busy && n < 2000);
      pix_cen   = 1'b0;
      spr_start = 1'b0;
      line_tgl  = 1'b0;
      fd        = 8'h00;
      chk({tag, "_len"}, 16'(n), 16'd512);
   endtask

   task automatic px(input logic start, input logic [8:0] y, input logic [7:0] d,
                     input logic tgl);
      pix_cen   = 1'b1;
      spr_start = start;
      fl_y      = y;
      fd        = d;
      line_tgl  = tgl;
      rd_x      = 9'd400;
      step();
      pix_cen   = 1'b0;
      spr_start = 1'b0;
      line_tgl  = 1'b0;
      fd        = 8'h00;
      step();
   endtask

   task automatic strip(input logic [8:0] y, input logic [7:0] d, input int n,
                        input logic tgl);
      px(1'b1, y, d, tgl);
      for (int i = 1; i < n; i++) px(1'b0, 9'd0, d, 1'b0);
   endtask

   task automatic toggle();
      line_tgl = 1'b1;
      step();
      line_tgl = 1'b0;
   endtask

   task automatic clr_img();
      for (int i = 0; i < 512; i++) img[i] = 8'h07;
   endtask

   task automatic paint(input int a, input logic [7:0] d, input int n);
      for (int i = 0; i < n; i++)
         if (d[2:0] != 3'b111) img[(a + i) % 512] = d;
   endtask

   task automatic sweep(input string tag, input int lo, input int hi);
      logic [8:0] e;
      for (int x = lo; x <= hi; x++) begin
         pix_cen = 1'b1;
         rd_x    = 9'(x);
         sb_q.push_back({img[x][2:0] != 3'b111, img[x]});
         step();
         pix_cen = 1'b0;
         rd_x    = ~9'(x);
         e = sb_q.pop_front();
         chk($sformatf("%s_rd[%0d]", tag, x), {7'd0, pix_valid, pix_out}, {7'd0, e});
         step();
         chk($sformatf("%s_hold[%0d]", tag, x), {7'd0, pix_valid, pix_out}, {7'd0, e});
         img[x] = 8'h07;
      end
   endtask

   initial begin
      logic [7:0] v;
      RESETn    = 1'b0;
      pix_cen   = 1'b0;
      line_tgl  = 1'b0;
      spr_start = 1'b0;
      fl_y      = 9'd0;
      fd        = 8'h00;
      rd_x      = 9'd0;

      // Reset and initial clear sweep
      repeat (4) step();
      chk("rst_pix", {7'd0, pix_valid, pix_out}, 16'h0007);
      chk("rst_busy", {15'd0, busy}, 16'd1);
      RESETn = 1'b1;
      wait_clear("clr1");
      clr_img();
      sweep("init_b", 0, 511);

      // Single strip at 100 into bank A, including transparent pixels
      for (int i = 0; i < 16; i++) begin
         v = (i == 5) ? 8'h27 : 8'(8'h21 + i);
         px(i == 0, 9'd100, v, 1'b0);
         paint(100 + i, v, 1);
      end
      px(1'b0, 9'd0, 8'h55, 1'b0);
      px(1'b0, 9'd0, 8'h55, 1'b0);
      toggle();
      sweep("strip_a", 0, 511);

      // Read-clear: the same bank again is empty
      toggle();
      toggle();
      sweep("rdclr_a", 0, 511);

      // Wrap and overlap into bank B; later strip wins
      strip(9'd508, 8'h31, 16, 1'b0);
      strip(9'd2, 8'h42, 16, 1'b0);
      paint(508, 8'h31, 16);
      paint(2, 8'h42, 16);
      toggle();
      sweep("wrap_b", 0, 511);

      // Restart, truncation and toggle coincident with a strip start
      strip(9'd50, 8'h61, 4, 1'b0);
      strip(9'd200, 8'h62, 6, 1'b0);
      strip(9'd300, 8'h63, 16, 1'b1);
      paint(50, 8'h61, 4);
      paint(200, 8'h62, 6);
      sweep("coll_a", 0, 511);
      toggle();
      paint(300, 8'h63, 16);
      sweep("coll_b", 0, 511);

      // Reset in the middle of a strip
      strip(9'd10, 8'h44, 3, 1'b0);
      pix_cen = 1'b1;
      fd      = 8'h44;
      RESETn  = 1'b0;
      step();
      pix_cen = 1'b0;
      chk("wrst_pix", {7'd0, pix_valid, pix_out}, 16'h0007);
      chk("wrst_busy", {15'd0, busy}, 16'd1);
      RESETn = 1'b1;
      wait_clear("clr2");

      // Reset in the middle of a readout
      strip(9'd10, 8'h44, 16, 1'b0);
      toggle();
      paint(10, 8'h44, 16);
      sweep("part_a", 0, 12);
      pix_cen = 1'b1;
      rd_x    = 9'd13;
      RESETn  = 1'b0;
      step();
      pix_cen = 1'b0;
      chk("rrst_pix", {7'd0, pix_valid, pix_out}, 16'h0007);
      chk("rrst_busy", {15'd0, busy}, 16'd1);
      RESETn = 1'b1;
      wait_clear("clr3");

      // Both banks fully cleared by the restarted sweep
      clr_img();
      sweep("fin_b", 0, 511);
      toggle();
      sweep("fin_a", 0, 511);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
      $finish;
   end

endmodule
